alu_arbiter: RTL and testbench

//  Shares the single 16-bit ALU between NREQ requesters (control FSM, address unit, debug port).

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter_rr.sv | 29 ++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, ALU function codes and the
// arbiter state encoding.
package alu_pkg;

    localparam int ALU_DW = 16;

    localparam logic [2:0] FN_B   = 3'd0;
    localparam logic [2:0] FN_ADD = 3'd1;
    localparam logic [2:0] FN_SUB = 3'd2;
    localparam logic [2:0] FN_AND = 3'd3;
    localparam logic [2:0] FN_OR  = 3'd4;
    localparam logic [2:0] FN_SHL = 3'd5;
    localparam logic [2:0] FN_SHR = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side and ALU-side signals of the shared-ALU arbiter.
// slave = arbiter view, master = requesters plus ALU.
interface alu_arbiter_if #(
    parameter int NREQ = 2,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ*3-1:0]  req_func;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               alu_en_in;
    logic [DW-1:0]      alu_a;
    logic [DW-1:0]      alu_b;
    logic [2:0]         alu_func;
    logic               alu_en_out;
    logic [DW-1:0]      alu_out;

    modport slave (
        input  req_valid, req_a, req_b, req_func, rsp_ready, alu_en_out, alu_out,
        output req_ready, rsp_valid, rsp_data, rsp_err, alu_en_in, alu_a, alu_b, alu_func
    );

    modport master (
        output req_valid, req_a, req_b, req_func, rsp_ready, alu_en_out, alu_out,
        input  req_ready, rsp_valid, rsp_data, rsp_err, alu_en_in, alu_a, alu_b, alu_func
    );
endinterface

// File: rtl/alu_arbiter_rr.sv
// Round-robin pick: first set request scanning upward from last grant + 1 with wrap.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);
    logic [IW-1:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = i_last;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = (w_cand == IW'(NREQ - 1)) ? '0 : w_cand + 1'b1;
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
        if (o_any) o_gnt[o_idx] = 1'b1;
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters; accept -> rsp_valid in 2 cycles, up to MAX_WAIT more before timeout.
// Response is held until the granted requester's rsp_ready; nothing new is accepted meanwhile.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int DW       = ALU_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave io_bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      r_state;
    logic [IW-1:0]   r_grant;
    logic [IW-1:0]   r_last;
    logic [3:0]      r_wait_cnt;
    logic            r_alu_en;
    logic [DW-1:0]   r_alu_a;
    logic [DW-1:0]   r_alu_b;
    logic [2:0]      r_alu_func;
    logic [DW-1:0]   r_rsp_data;
    logic            r_rsp_err;
    logic [NREQ-1:0] r_rsp_vld;

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic [NREQ-1:0] w_rsp_oh;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .i_req (io_bus.req_valid),
        .i_last(r_last),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_rsp_oh = NREQ'(1) << r_grant;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_last     <= IW'(NREQ - 1);
            r_wait_cnt <= '0;
            r_alu_en   <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_func <= 3'b000;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp_vld  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // ready is the grant itself, so any pending request transfers now
                    if (w_any) begin
                        r_alu_a    <= io_bus.req_a[w_idx*DW +: DW];
                        r_alu_b    <= io_bus.req_b[w_idx*DW +: DW];
                        r_alu_func <= io_bus.req_func[w_idx*3 +: 3];
                        r_grant    <= w_idx;
                        r_alu_en   <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (io_bus.alu_en_out) begin
                        r_rsp_data <= io_bus.alu_out;
                        r_rsp_err  <= 1'b0;
                        r_rsp_vld  <= w_rsp_oh;
                        r_alu_en   <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= ST_RESP;
                    end else if (r_state == ST_ISSUE) begin
                        r_wait_cnt <= 4'd1;
                        r_state    <= ST_WAIT;
                    end else if (r_wait_cnt == 4'(MAX_WAIT)) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                        r_rsp_vld  <= w_rsp_oh;
                        r_alu_en   <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    if (io_bus.rsp_ready[r_grant]) begin
                        r_rsp_vld <= '0;
                        r_last    <= r_grant;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.req_ready = (r_state == ST_IDLE) ? w_gnt : '0;
    assign io_bus.rsp_valid = r_rsp_vld;
    assign io_bus.rsp_data  = r_rsp_data;
    assign io_bus.rsp_err   = r_rsp_err;
    assign io_bus.alu_en_in = r_alu_en;
    assign io_bus.alu_a     = r_alu_a;
    assign io_bus.alu_b     = r_alu_b;
    assign io_bus.alu_func  = r_alu_func;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an ALU responder, a transaction-level
// reference model checked every cycle, and literal per-scenario expectations.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NREQ     = 2;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    alu_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] alu_ref(logic [2:0] f, logic [DW-1:0] a, logic [DW-1:0] b);
        case (f)
            FN_B:    return b;
            FN_ADD:  return a + b;
            FN_SUB:  return a - b;
            FN_AND:  return a & b;
            FN_OR:   return a | b;
            FN_SHL:  return a << b[3:0];
            FN_SHR:  return a >> b[3:0];
            default: return '0;
        endcase
    endfunction

    // ALU responder: answers once alu_en_in has been high for alu_lat earlier cycles
    bit alu_hang = 1'b0;
    int alu_lat  = 0;
    int en_run   = 0;
    always @(posedge clk) en_run <= (bus.alu_en_in === 1'b1) ? en_run + 1 : 0;
    always_comb begin
        bus.alu_en_out = bus.alu_en_in && !alu_hang && (en_run >= alu_lat);
        bus.alu_out    = bus.alu_en_out ? alu_ref(bus.alu_func, bus.alu_a, bus.alu_b) : '0;
    end

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        int            en;
    } rsp_t;
    rsp_t rsp_q[$];
    int   acc_q[$];

    bit chk_on = 1'b0;
    int cyc = 0, acc_cyc = 0, en_cnt = 0;

    // Reference model state: one outstanding op at a time
    bit            m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
    int            m_g = 0, m_last = NREQ - 1, m_en = 0;
    logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [2:0]    m_f = '0;

    function automatic int rr_pick(logic [NREQ-1:0] v, int last);
        for (int i = last + 1; i < NREQ; i++) if (v[i]) return i;
        for (int i = 0; i <= last; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int oh_idx(logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        int              w;
        logic [NREQ-1:0] e_rdy;
        if (chk_on) begin
            cyc++;
            w     = rr_pick(bus.req_valid, m_last);
            e_rdy = '0;
            if (!m_busy && w >= 0) e_rdy[w] = 1'b1;
            chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
            chk("alu_en_in", 32'(bus.alu_en_in), 32'(m_busy && !m_done));
            chk("rsp_valid", 32'(bus.rsp_valid), m_done ? (32'd1 << m_g) : 32'd0);
            chk("alu_a", 32'(bus.alu_a), 32'(m_a));
            chk("alu_b", 32'(bus.alu_b), 32'(m_b));
            chk("alu_func", 32'(bus.alu_func), 32'(m_f));
            if (m_done) begin
                chk("rsp_data", 32'(bus.rsp_data), m_err ? 32'd0 : 32'(m_res));
                chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
            end
            if (rst) begin
                if (|(bus.req_valid & bus.req_ready)) begin
                    acc_q.push_back(oh_idx(bus.req_valid & bus.req_ready));
                    acc_cyc = cyc;
                    en_cnt  = 0;
                end else if (bus.alu_en_in) begin
                    en_cnt++;
                end
                if (|(bus.rsp_valid & bus.rsp_ready))
                    rsp_q.push_back('{oh_idx(bus.rsp_valid), bus.rsp_data, bus.rsp_err,
                                      cyc - acc_cyc, en_cnt});
            end
            if (!rst) begin
                m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_last = NREQ - 1;
                m_a = '0; m_b = '0; m_f = '0;
            end else if (!m_busy) begin
                if (w >= 0) begin
                    m_busy = 1'b1;
                    m_g    = w;
                    m_en   = 0;
                    m_a    = bus.req_a[w*DW +: DW];
                    m_b    = bus.req_b[w*DW +: DW];
                    m_f    = bus.req_func[w*3 +: 3];
                    m_res  = alu_ref(m_f, m_a, m_b);
                end
            end else if (!m_done) begin
                m_en++;
                if (bus.alu_en_out) begin
                    m_done = 1'b1; m_err = 1'b0;
                end else if (m_en == MAX_WAIT + 1) begin
                    m_done = 1'b1; m_err = 1'b1;
                end
            end else if (bus.rsp_ready[m_g]) begin
                m_busy = 1'b0; m_done = 1'b0; m_last = m_g;
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_acc(int n, string nm);
        for (int c = 0; c < 200 && acc_q.size() < n; c++) tick();
        if (acc_q.size() < n) begin
            n_vec++; n_err++;
            $display("FAIL %s_accept: got %0d accepts, want %0d", nm, acc_q.size(), n);
        end
    endtask

    task automatic wait_rsp(int n, string nm);
        for (int c = 0; c < 200 && rsp_q.size() < n; c++) tick();
        if (rsp_q.size() < n) begin
            n_vec++; n_err++;
            $display("FAIL %s_response: got %0d responses, want %0d", nm, rsp_q.size(), n);
        end
    endtask

    task automatic drive(int i, logic [DW-1:0] a, logic [DW-1:0] b, logic [2:0] f);
        bus.req_a[i*DW +: DW]  = a;
        bus.req_b[i*DW +: DW]  = b;
        bus.req_func[i*3 +: 3] = f;
        bus.req_valid[i]       = 1'b1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic op(string nm, int i, logic [DW-1:0] a, logic [DW-1:0] b, logic [2:0] f,
                      logic [DW-1:0] ed, logic ee, int el, int een);
        acc_q.delete();
        rsp_q.delete();
        drive(i, a, b, f);
        #1 chk({nm, "_ready_now"}, 32'(bus.req_ready), 32'd1 << i);
        wait_acc(1, nm);
        bus.req_valid = '0;
        wait_rsp(1, nm);
        if (rsp_q.size() > 0) begin
            chk({nm, "_idx"}, rsp_q[0].idx, i);
            chk({nm, "_data"}, 32'(rsp_q[0].data), 32'(ed));
            chk({nm, "_err"}, 32'(rsp_q[0].err), 32'(ee));
            chk({nm, "_lat"}, rsp_q[0].lat, el);
            chk({nm, "_en_cycles"}, rsp_q[0].en, een);
        end
    endtask

    task automatic wait_rv0();
        for (int c = 0; c < 50 && bus.rsp_valid[0] !== 1'b1; c++) tick();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_func  = '0;
        bus.rsp_ready = '1;
        rst = 1'b0;
        tick(1);
        chk_on = 1'b1;
        tick(1);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_alu_en", 32'(bus.alu_en_in), 32'd0);
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
        chk("rst_alu_func", 32'(bus.alu_func), 32'd0);
        rst = 1'b1;
        tick(1);

        // single op, ALU answers in the issue cycle
        op("single_add", 0, 16'h0005, 16'h0003, FN_ADD, 16'h0008, 1'b0, 2, 1);

        // contention from reset: grants alternate 0,1,0,1
        do_reset();
        acc_q.delete(); rsp_q.delete();
        drive(0, 16'h0010, 16'h0001, FN_SUB);
        drive(1, 16'hF0F0, 16'h0FF0, FN_AND);
        wait_acc(4, "contend");
        bus.req_valid = '0;
        wait_rsp(4, "contend");
        if (acc_q.size() >= 4 && rsp_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("contend_grant", acc_q[k], k % 2);
                chk("contend_rsp_idx", rsp_q[k].idx, k % 2);
                chk("contend_rsp_data", 32'(rsp_q[k].data), (k % 2 == 0) ? 32'h000F : 32'h00F0);
            end
        end

        // response backpressure on requester 0 while requester 1 waits
        acc_q.delete(); rsp_q.delete();
        bus.rsp_ready = 2'b10;
        drive(0, 16'h1200, 16'h0034, FN_OR);
        wait_acc(1, "bp");
        bus.req_valid = '0;
        drive(1, 16'h0000, 16'hBEEF, FN_B);
        wait_rv0();
        repeat (5) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(bus.rsp_data), 32'h1234);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        chk("bp_no_accept", acc_q.size(), 1);
        bus.rsp_ready = 2'b11;
        wait_acc(2, "bp2");
        bus.req_valid = '0;
        wait_rsp(2, "bp2");
        if (acc_q.size() >= 2 && rsp_q.size() >= 2) begin
            chk("bp_second_grant", acc_q[1], 1);
            chk("bp_rsp0_data", 32'(rsp_q[0].data), 32'h1234);
            chk("bp_rsp1_idx", rsp_q[1].idx, 1);
            chk("bp_rsp1_data", 32'(rsp_q[1].data), 32'hBEEF);
        end

        // timeout: ALU never answers
        alu_hang = 1'b1;
        op("timeout", 0, 16'h0001, 16'h0002, FN_ADD, 16'h0000, 1'b1, 6, 5);

        // reset in the middle of a waiting op
        acc_q.delete(); rsp_q.delete();
        drive(0, 16'h0007, 16'h0001, FN_ADD);
        wait_acc(1, "midrst");
        bus.req_valid = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("midrst_alu_en", 32'(bus.alu_en_in), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("midrst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("midrst_alu_func", 32'(bus.alu_func), 32'd0);
        rst = 1'b1;
        alu_hang = 1'b0;
        tick(8);
        chk("midrst_no_rsp", rsp_q.size(), 0);
        acc_q.delete(); rsp_q.delete();
        drive(0, 16'h0003, 16'h0001, FN_SUB);
        drive(1, 16'h0100, 16'h0001, FN_OR);
        wait_acc(1, "midrst_first");
        bus.req_valid = '0;
        wait_rsp(1, "midrst_first");
        if (acc_q.size() >= 1 && rsp_q.size() >= 1) begin
            chk("midrst_first_grant", acc_q[0], 0);
            chk("midrst_first_data", 32'(rsp_q[0].data), 32'h0002);
        end

        // shifts, wrap-around, undefined code, slow ALU
        op("shl", 1, 16'h8001, 16'h0001, FN_SHL, 16'h0002, 1'b0, 2, 1);
        op("add_wrap", 0, 16'hFFFF, 16'h0001, FN_ADD, 16'h0000, 1'b0, 2, 1);
        op("undef_fn", 1, 16'h1234, 16'h5678, 3'b111, 16'h0000, 1'b0, 2, 1);
        alu_lat = 2;
        op("slow_alu", 0, 16'h1234, 16'h1111, FN_ADD, 16'h2345, 1'b0, 4, 3);
        alu_lat = 0;

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end
endmodule
